// File: rtl/pc_stack_ctrl_pkg.sv
// Shared types for the PC sequencer: op encoding, branch condition codes
// and the flag-based condition evaluator.
package pc_stack_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NEXT = 2'b00,
        OP_JUMP = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } op_e;

    localparam logic [3:0] COND_ALWAYS = 4'b1111;
    localparam logic [3:0] COND_EQ     = 4'b0001;
    localparam logic [3:0] COND_NE     = 4'b0010;
    localparam logic [3:0] COND_GT     = 4'b0011;
    localparam logic [3:0] COND_GE     = 4'b0100;
    localparam logic [3:0] COND_LT     = 4'b0101;
    localparam logic [3:0] COND_LE     = 4'b0110;
    localparam logic [3:0] COND_CS     = 4'b0111;
    localparam logic [3:0] COND_CC     = 4'b1000;

    // Unlisted codes evaluate to never-taken.
    function automatic logic cond_eval(logic [3:0] cond, logic z, logic n, logic c);
        case (cond)
            COND_ALWAYS: return 1'b1;
            COND_EQ:     return z;
            COND_NE:     return !z;
            COND_GT:     return !z && !n;
            COND_GE:     return !n;
            COND_LT:     return n;
            COND_LE:     return n || z;
            COND_CS:     return c;
            COND_CC:     return !c;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pc_stack_ctrl_if.sv
// Control-unit <-> sequencer bus: op/cond/target/flags in, pc and stack status out.
interface pc_stack_ctrl_if #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int SP_W        = $clog2(STACK_DEPTH + 1)
);
    logic              en;
    logic [1:0]        op;
    logic [3:0]        cond;
    logic [ADDR_W-1:0] target;
    logic              flag_z;
    logic              flag_n;
    logic              flag_c;
    logic [ADDR_W-1:0] pc;
    logic              taken;
    logic [SP_W-1:0]   sp;
    logic              stack_full;
    logic              stack_empty;
    logic              err_ovf;
    logic              err_unf;

    modport master (
        output en, op, cond, target, flag_z, flag_n, flag_c,
        input  pc, taken, sp, stack_full, stack_empty, err_ovf, err_unf
    );

    modport slave (
        input  en, op, cond, target, flag_z, flag_n, flag_c,
        output pc, taken, sp, stack_full, stack_empty, err_ovf, err_unf
    );
endinterface

// File: rtl/pc_stack_ctrl_ret_stack.sv
// Return-address LIFO. Push-when-full and pop-when-empty are silently dropped;
// the caller reports them as errors.
module ret_stack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    localparam int SP_W       = $clog2(STACK_DEPTH + 1),
    localparam int IDX_W      = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] dout,
    output logic [SP_W-1:0]   sp,
    output logic              full,
    output logic              empty
);
    logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
    logic [SP_W-1:0]   sp_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (sp_q == SP_W'(STACK_DEPTH));
    assign empty   = (sp_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign sp      = sp_q;
    assign dout    = mem_q[IDX_W'(sp_q - SP_W'(1))];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
        end else if (do_push) begin
            sp_q <= sp_q + SP_W'(1);
        end else if (do_pop) begin
            sp_q <= sp_q - SP_W'(1);
        end
    end

    // Entries need no reset: sp alone defines what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[IDX_W'(sp_q)] <= din;
        end
    end

endmodule

// File: rtl/pc_stack_ctrl.sv
// Program-counter sequencer for fetch: NEXT/JUMP/CALL/RET with condition codes,
// a return-address stack, stall support and sticky stack-error flags.
module pc_stack_ctrl
    import pc_stack_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pc_stack_ctrl_if.slave       bus
);
    logic [ADDR_W-1:0] pc_q, pc_d, seq, tos;
    logic              taken_q, taken_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              push, pop, full, empty, cond_ok;

    assign seq     = pc_q + ADDR_W'(1);
    assign cond_ok = cond_eval(bus.cond, bus.flag_z, bus.flag_n, bus.flag_c);

    ret_stack #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (seq),
        .dout  (tos),
        .sp    (bus.sp),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        pc_d    = pc_q;
        taken_d = 1'b0;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (bus.en) begin
            pc_d = seq;
            case (op_e'(bus.op))
                OP_JUMP: if (cond_ok) begin
                    pc_d    = bus.target;
                    taken_d = 1'b1;
                end
                OP_CALL: if (cond_ok) begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        push    = 1'b1;
                        pc_d    = bus.target;
                        taken_d = 1'b1;
                    end
                end
                OP_RET: if (cond_ok) begin
                    if (empty) begin
                        unf_d = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        pc_d    = tos;
                        taken_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            taken_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            taken_q <= taken_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.taken       = taken_q;
    assign bus.stack_full  = full;
    assign bus.stack_empty = empty;
    assign bus.err_ovf     = ovf_q;
    assign bus.err_unf     = unf_q;

endmodule

// File: tb/tb_pc_stack_ctrl.sv
// Bench for pc_stack_ctrl: directed scenarios with literal expectations, then
// randomized traffic against a queue-based reference model.
module tb_pc_stack_ctrl;
    localparam int AW = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pc_stack_ctrl_if #(.ADDR_W(AW), .STACK_DEPTH(DEPTH)) bus();
    pc_stack_ctrl #(.ADDR_W(AW), .STACK_DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Reference model state
    int       m_pc, m_taken, m_ovf, m_unf;
    int       m_stack[$];

    function automatic bit cond_ref(bit [3:0] c, bit z, bit n, bit cy);
        case (c)
            4'hF: return 1;
            4'h1: return z;
            4'h2: return !z;
            4'h3: return !z && !n;
            4'h4: return !n;
            4'h5: return n;
            4'h6: return n || z;
            4'h7: return cy;
            4'h8: return !cy;
            default: return 0;
        endcase
    endfunction

    // {pc, taken, sp, ovf, unf, full, empty}
    function automatic logic [15:0] obs();
        return {bus.pc, bus.taken, bus.sp, bus.err_ovf, bus.err_unf, bus.stack_full, bus.stack_empty};
    endfunction

    function automatic logic [15:0] expv(int pc, int tk, int sp, int ovf, int unf);
        logic [15:0] v;
        v = {pc[7:0], tk[0], sp[2:0], ovf[0], unf[0], (sp == DEPTH), (sp == 0)};
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.en = 1'b0; bus.op = 2'b00; bus.cond = 4'h0; bus.target = '0;
        bus.flag_z = 1'b0; bus.flag_n = 1'b0; bus.flag_c = 1'b0;
        #2 rst_n = 1'b1;
        m_pc = 0; m_taken = 0; m_ovf = 0; m_unf = 0;
        m_stack.delete();
        @(negedge clk);
    endtask

    // Drive one op for one clock, advance the model, return at the next negedge.
    task automatic step(bit e, bit [1:0] o, bit [3:0] c, int t, bit z = 0, bit n = 0, bit cy = 0);
        int seq;
        bit ok;
        bus.en = e; bus.op = o; bus.cond = c; bus.target = t[7:0];
        bus.flag_z = z; bus.flag_n = n; bus.flag_c = cy;
        @(posedge clk);
        seq = (m_pc + 1) % 256;
        ok = cond_ref(c, z, n, cy);
        m_taken = 0;
        if (e) begin
            m_pc = seq;
            if (ok && o == 2'b01) begin
                m_pc = t; m_taken = 1;
            end else if (ok && o == 2'b10) begin
                if (m_stack.size() == DEPTH) m_ovf = 1;
                else begin m_stack.push_back(seq); m_pc = t; m_taken = 1; end
            end else if (ok && o == 2'b11) begin
                if (m_stack.size() == 0) m_unf = 1;
                else begin m_pc = m_stack.pop_back(); m_taken = 1; end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs() !== expv(0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL reset: got %h want %h", obs(), expv(0, 0, 0, 0, 0));
        end
        for (int i = 1; i <= 3; i++) begin
            step(1, 2'b00, 4'hF, 8'h77);
            checks++;
            if (obs() !== expv(i, 0, 0, 0, 0)) begin
                errors++; $display("FAIL next_%0d: got %h want %h", i, obs(), expv(i, 0, 0, 0, 0));
            end
        end
    endtask

    task automatic test_jump();
        step(1, 2'b00, 4'h0, 0);
        step(1, 2'b00, 4'h0, 0);
        step(1, 2'b01, 4'h1, 8'h40, 0);
        checks++;
        if (obs() !== expv(6, 0, 0, 0, 0)) begin
            errors++; $display("FAIL jump_eq_z0: got %h want %h", obs(), expv(6, 0, 0, 0, 0));
        end
        step(1, 2'b01, 4'h1, 8'h40, 1);
        checks++;
        if (obs() !== expv(8'h40, 1, 0, 0, 0)) begin
            errors++; $display("FAIL jump_eq_z1: got %h want %h", obs(), expv(8'h40, 1, 0, 0, 0));
        end
        step(1, 2'b01, 4'hA, 8'h90, 1, 1, 1);
        checks++;
        if (obs() !== expv(8'h41, 0, 0, 0, 0)) begin
            errors++; $display("FAIL jump_never: got %h want %h", obs(), expv(8'h41, 0, 0, 0, 0));
        end
    endtask

    task automatic test_nested_call();
        do_reset();
        repeat (3) step(1, 2'b00, 4'h0, 0);
        step(1, 2'b10, 4'hF, 8'h10);
        step(1, 2'b10, 4'hF, 8'h20);
        checks++;
        if (obs() !== expv(8'h20, 1, 2, 0, 0)) begin
            errors++; $display("FAIL call_nested: got %h want %h", obs(), expv(8'h20, 1, 2, 0, 0));
        end
        step(1, 2'b11, 4'hF, 0);
        checks++;
        if (obs() !== expv(8'h11, 1, 1, 0, 0)) begin
            errors++; $display("FAIL ret_inner: got %h want %h", obs(), expv(8'h11, 1, 1, 0, 0));
        end
        step(1, 2'b11, 4'hF, 0);
        checks++;
        if (obs() !== expv(4, 1, 0, 0, 0)) begin
            errors++; $display("FAIL ret_outer: got %h want %h", obs(), expv(4, 1, 0, 0, 0));
        end
    endtask

    task automatic test_ovf_unf();
        int rets[4] = '{8'h21, 8'h19, 8'h11, 1};
        do_reset();
        step(1, 2'b10, 4'hF, 8'h10);
        step(1, 2'b10, 4'hF, 8'h18);
        step(1, 2'b10, 4'hF, 8'h20);
        step(1, 2'b10, 4'hF, 8'h30);
        checks++;
        if (obs() !== expv(8'h30, 1, 4, 0, 0)) begin
            errors++; $display("FAIL fill: got %h want %h", obs(), expv(8'h30, 1, 4, 0, 0));
        end
        step(1, 2'b10, 4'hF, 8'h50);
        checks++;
        if (obs() !== expv(8'h31, 0, 4, 1, 0)) begin
            errors++; $display("FAIL overflow: got %h want %h", obs(), expv(8'h31, 0, 4, 1, 0));
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 2'b11, 4'hF, 0);
            checks++;
            if (obs() !== expv(rets[i], 1, 3 - i, 1, 0)) begin
                errors++; $display("FAIL drain_%0d: got %h want %h", i, obs(), expv(rets[i], 1, 3 - i, 1, 0));
            end
        end
        step(1, 2'b11, 4'hF, 0);
        checks++;
        if (obs() !== expv(2, 0, 0, 1, 1)) begin
            errors++; $display("FAIL underflow: got %h want %h", obs(), expv(2, 0, 0, 1, 1));
        end
        step(1, 2'b01, 4'hF, 8'h70);
        checks++;
        if (obs() !== expv(8'h70, 1, 0, 1, 1)) begin
            errors++; $display("FAIL sticky: got %h want %h", obs(), expv(8'h70, 1, 0, 1, 1));
        end
        do_reset();
        checks++;
        if (obs() !== expv(0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL err_clear: got %h want %h", obs(), expv(0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(1, 2'b01, 4'hF, 8'hFF);
        step(1, 2'b00, 4'h0, 0);
        checks++;
        if (obs() !== expv(0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL wrap_next: got %h want %h", obs(), expv(0, 0, 0, 0, 0));
        end
        step(1, 2'b01, 4'hF, 8'hFF);
        step(1, 2'b10, 4'hF, 8'h80);
        checks++;
        if (obs() !== expv(8'h80, 1, 1, 0, 0)) begin
            errors++; $display("FAIL wrap_call: got %h want %h", obs(), expv(8'h80, 1, 1, 0, 0));
        end
        step(1, 2'b11, 4'hF, 0);
        checks++;
        if (obs() !== expv(0, 1, 0, 0, 0)) begin
            errors++; $display("FAIL wrap_ret: got %h want %h", obs(), expv(0, 1, 0, 0, 0));
        end
    endtask

    task automatic test_stall_async_reset();
        do_reset();
        repeat (3) step(1, 2'b10, 4'hF, 8'h10);
        step(1, 2'b10, 4'hF, 8'h60);
        for (int i = 0; i < 3; i++) begin
            step(0, 2'b10, 4'hF, 8'h99);
            checks++;
            if (obs() !== expv(8'h60, 0, 4, 0, 0)) begin
                errors++; $display("FAIL stall_%0d: got %h want %h", i, obs(), expv(8'h60, 0, 4, 0, 0));
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== expv(0, 0, 0, 0, 0)) begin
            errors++; $display("FAIL async_reset: got %h want %h", obs(), expv(0, 0, 0, 0, 0));
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [15:0] want;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bit [3:0] c;
            c = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            step($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), c, $urandom_range(0, 255),
                 1'($urandom), 1'($urandom), 1'($urandom));
            want = expv(m_pc, m_taken, m_stack.size(), m_ovf, m_unf);
            checks++;
            if (obs() !== want) begin
                errors++; $display("FAIL random_%0d: got %h want %h", i, obs(), want);
            end
            if ($urandom_range(0, 99) == 0) do_reset();
        end
    endtask

    initial begin
        bus.en = 1'b0; bus.op = 2'b00; bus.cond = 4'h0; bus.target = '0;
        bus.flag_z = 1'b0; bus.flag_n = 1'b0; bus.flag_c = 1'b0;
        test_reset();
        test_jump();
        test_nested_call();
        test_ovf_unf();
        test_wrap();
        test_stall_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_stack_ctrl.md
Name: pc_stack_ctrl

Overview:
- Parametrised program-counter sequencer for the CPU fetch stage.
- Generalises the plain PC+jump logic to configurable address width and a full ALU-flag condition set.
- Adds CALL/RET through an internal return-address stack, a stall input, and sticky stack-error reporting.
- Sits between the control unit (op/cond/target) and instruction memory (pc address).

Parameters:
- ADDR_W, 8, PC and target width in bits.
- STACK_DEPTH, 4, number of return-address entries (>=1).
- SP_W, $clog2(STACK_DEPTH+1), stack-pointer width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  advance enable; 0 = stall (hold all state)
- op  in  2  00 NEXT, 01 JUMP, 10 CALL, 11 RET
- cond  in  4  branch condition code (applies to JUMP/CALL/RET)
- target  in  ADDR_W  literal destination for JUMP/CALL
- flag_z  in  1  ALU zero flag
- flag_n  in  1  ALU negative flag
- flag_c  in  1  ALU carry flag
- pc  out  ADDR_W  current program counter
- taken  out  1  registered; 1 for the cycle after a redirect was taken
- sp  out  SP_W  stack occupancy, 0..STACK_DEPTH
- stack_full  out  1  sp == STACK_DEPTH (combinational from sp)
- stack_empty  out  1  sp == 0 (combinational from sp)
- err_ovf  out  1  sticky: a CALL was attempted while full
- err_unf  out  1  sticky: a RET was attempted while empty

Behaviour:
- Reset (rst_n=0, asynchronous): pc=0, sp=0, taken=0, err_ovf=0, err_unf=0. Stack contents are don't-care.
- Condition codes (cond_true):
  - 1111 ALWAYS
  - 0001 EQ: Z
  - 0010 NE: !Z
  - 0011 GT: !Z&!N
  - 0100 GE: !N
  - 0101 LT: N
  - 0110 LE: N|Z
  - 0111 CS: C
  - 1000 CC: !C
  - All other codes: NEVER (not taken).
- Flags are sampled in the same cycle as op. All updates occur at posedge clk when en=1. Single-cycle latency: the new pc is visible the cycle after op.
- en=0: pc, sp, stack and err flags hold; taken<=0. Op is ignored entirely, with no error even if it would overflow.
- Sequential address: seq = pc+1 modulo 2^ADDR_W (e.g. 255 -> 0 at ADDR_W=8).
- NEXT: pc<=seq; taken<=0. cond is ignored.
- JUMP:
  - cond_true: pc<=target; taken<=1.
  - Otherwise: pc<=seq; taken<=0.
- CALL:
  - cond_true & !full: push seq at stack[sp]; sp<=sp+1; pc<=target; taken<=1.
  - cond_true & full: no push; pc<=seq; taken<=0; err_ovf<=1.
  - !cond_true: pc<=seq; no stack change.
- RET:
  - cond_true & !empty: pc<=stack[sp-1]; sp<=sp-1; taken<=1.
  - cond_true & empty: pc<=seq; taken<=0; err_unf<=1.
  - !cond_true: pc<=seq.
- A CALL at pc=2^ADDR_W-1 pushes 0 (wrapped return address).
- Error flags stay set until reset and never block further operation.
- Only one op is issued per cycle, so push and pop cannot occur together.
- Reset asserted mid-sequence clears everything immediately. The stack is logically empty afterwards regardless of old contents.

Decomposition:
- pc_pkg holds:
  - op enum: OP_NEXT, OP_JUMP, OP_CALL, OP_RET.
  - 4-bit cond localparams: COND_ALWAYS=4'b1111, COND_EQ=4'b0001, ... COND_CC=4'b1000.
  - A cond_eval function (cond, z, n, c) -> bit.
- One sub-module: ret_stack.
  - Parametrised LIFO with ADDR_W and STACK_DEPTH.
  - Ports: clk, rst_n, push, pop, din, dout (top-of-stack, combinational), sp, full, empty.
  - Guards push-when-full and pop-when-empty internally.
- The top level holds pc, taken, the err flags, and next-pc muxing.

Test Plan:
- Reset, then 3 cycles of NEXT with en=1 -> pc 0,1,2,3; taken=0; sp=0; stack_empty=1.
- At pc=5: JUMP cond=0001 target=0x40 with Z=0 -> pc=6, taken=0. Repeat with Z=1 -> pc=0x40, taken=1. Then cond=1010 -> pc=0x41, not taken.
- Nested calls with STACK_DEPTH=4:
  - CALL target=0x10 at pc=3, then CALL 0x20 at pc=0x10 -> sp=2, pc=0x20.
  - RET -> pc=0x11; RET -> pc=4; sp=0.
- Overflow/underflow:
  - 4 CALLs fill the stack (stack_full=1). A 5th CALL from pc=0x30 -> pc=0x31, sp=4, err_ovf=1.
  - Drain with 4 RETs, then a 5th RET -> err_unf=1, pc=seq.
  - Both flags remain 1 until rst_n pulse.
- Wrap: pc=0xFF, NEXT -> pc=0x00. CALL at 0xFF to 0x80 then RET -> pc=0x00.
- Stall and async reset:
  - en=0 for 3 cycles while op=CALL cond=1111 -> pc, sp unchanged, taken=0, no error.
  - Assert rst_n=0 between clock edges -> pc=0, sp=0 immediately, without waiting for clk.
